// File: rtl/ftdi_laser_framer.sv
// ftdi_laser_framer: wraps PKT_BYTES-byte blocks from the FTDI read queue into
// sync/seq/payload[/checksum] frames on a byte valid/ready stream.
// Optional trailing checksum byte: define LDROP_TX_CHECKSUM_EN.
module ftdi_laser_framer #(
   parameter int         PKT_BYTES = 1024,
   parameter logic [7:0] SYNC0     = 8'hAA,
   parameter logic [7:0] SYNC1     = 8'h55
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        en,
   input  logic [16:0] rd_qsize,
   input  logic        rdq_empty,
   input  logic [7:0]  data_rd,
   output logic        rdreq,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        frame_done,
   output logic        busy,
   output logic [15:0] frames_sent
);
   typedef enum logic [2:0] {
      IDLE, HDR0, HDR1, HDR_SEQ, PAY_REQ, PAY_LAT, PAY_OUT
`ifdef LDROP_TX_CHECKSUM_EN
      , TRAIL
`endif
   } state_t;

   state_t      state, state_n;
   logic [7:0]  seq, pay;
   logic [10:0] cnt;
   logic        pay_last;
`ifdef LDROP_TX_CHECKSUM_EN
   logic [7:0]  chk;
`endif

   assign pay_last = cnt == 11'(PKT_BYTES - 1);
   assign busy     = state != IDLE;

   // Next state and stream outputs; clear suppresses pops and completion.
   always_comb begin
      state_n    = state;
      rdreq      = 1'b0;
      out_valid  = 1'b0;
      out_data   = 8'h00;
      frame_done = 1'b0;
      case (state)
         IDLE:    if (en && rd_qsize >= 17'(PKT_BYTES)) state_n = HDR0;
         HDR0: begin
            out_valid = 1'b1;
            out_data  = SYNC0;
            if (out_ready) state_n = HDR1;
         end
         HDR1: begin
            out_valid = 1'b1;
            out_data  = SYNC1;
            if (out_ready) state_n = HDR_SEQ;
         end
         HDR_SEQ: begin
            out_valid = 1'b1;
            out_data  = seq;
            if (out_ready) state_n = PAY_REQ;
         end
         PAY_REQ: begin
            rdreq = !rdq_empty;
            if (!rdq_empty) state_n = PAY_LAT;
         end
         PAY_LAT: state_n = PAY_OUT;
         PAY_OUT: begin
            out_valid = 1'b1;
            out_data  = pay;
            if (out_ready) begin
`ifdef LDROP_TX_CHECKSUM_EN
               state_n = pay_last ? TRAIL : PAY_REQ;
`else
               state_n    = pay_last ? IDLE : PAY_REQ;
               frame_done = pay_last;
`endif
            end
         end
`ifdef LDROP_TX_CHECKSUM_EN
         TRAIL: begin
            out_valid  = 1'b1;
            out_data   = chk;
            frame_done = out_ready;
            if (out_ready) state_n = IDLE;
         end
`endif
         default: state_n = IDLE;
      endcase
      if (clear) begin
         state_n    = IDLE;
         rdreq      = 1'b0;
         frame_done = 1'b0;
      end
   end

   // State, payload datapath and frame bookkeeping.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         seq         <= 8'h00;
         pay         <= 8'h00;
         cnt         <= 11'd0;
         frames_sent <= 16'd0;
`ifdef LDROP_TX_CHECKSUM_EN
         chk         <= 8'h00;
`endif
      end else if (clear) begin
         state       <= IDLE;
         seq         <= 8'h00;
         pay         <= 8'h00;
         cnt         <= 11'd0;
         frames_sent <= 16'd0;
`ifdef LDROP_TX_CHECKSUM_EN
         chk         <= 8'h00;
`endif
      end else begin
         state <= state_n;
         if (state == IDLE) begin
            cnt <= 11'd0;
`ifdef LDROP_TX_CHECKSUM_EN
            chk <= seq;
`endif
         end
         if (state == PAY_LAT) begin
            pay <= data_rd;
`ifdef LDROP_TX_CHECKSUM_EN
            chk <= chk + data_rd;
`endif
         end
         if (state == PAY_OUT && out_ready && !pay_last) cnt <= cnt + 11'd1;
         if (frame_done) begin
            seq         <= seq + 8'd1;
            frames_sent <= frames_sent + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_ftdi_laser_framer.sv
// tb_ftdi_laser_framer: randomized directed bench for ftdi_laser_framer with
// a frame-level reference model and a queue-level read FIFO emulation.
module tb_ftdi_laser_framer;
   localparam int P = 4;
`ifdef LDROP_TX_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif
   localparam int FL  = P + 3 + CK;
   localparam int CYC = 3 + 3 * P + CK;

   logic        clock = 1'b0, reset = 1'b1, clear = 1'b0, en = 1'b0;
   logic        rdq_empty = 1'b1, out_ready = 1'b0;
   logic [16:0] rd_qsize = 17'd0;
   logic [7:0]  data_rd = 8'h00;
   logic        rdreq, out_valid, frame_done, busy;
   logic [7:0]  out_data;
   logic [15:0] frames_sent;

   ftdi_laser_framer #(.PKT_BYTES(P), .SYNC0(8'hAA), .SYNC1(8'h55)) dut (
      .clock(clock), .reset(reset), .clear(clear), .en(en),
      .rd_qsize(rd_qsize), .rdq_empty(rdq_empty), .data_rd(data_rd),
      .rdreq(rdreq), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .frame_done(frame_done), .busy(busy),
      .frames_sent(frames_sent)
   );

   always #5 clock = ~clock;

   int         checks = 0, failures = 0;
   logic [7:0] q[$], got[$], exp_b[$];
   int         ready_mode = 0, force_left = 0, pops = 0, fd_cnt = 0;
   int         busy_cyc = 0, idle_cyc = 0, stall_rd = 0;
   bit         seen_busy = 0, have_pend = 0, clear_req = 0;
   logic [7:0] pend = 8'h00, mseq = 8'h00, prev_d = 8'h00;
   logic       prev_v = 1'b0, prev_r = 1'b0, prev_c = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
      if (have_pend) begin
         data_rd   = pend;
         have_pend = 0;
      end
      if (force_left > 0) force_left--;
      rd_qsize  = 17'(q.size());
      rdq_empty = (q.size() == 0) || (force_left > 0);
      out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
      clear     = clear_req;
      clear_req = 0;
      @(negedge clock);
      if (prev_v && !prev_r && !prev_c) begin
         check("stall_valid", 32'(out_valid), 1);
         check("stall_data", 32'(out_data), 32'(prev_d));
      end
      if (out_valid && out_ready && !clear) got.push_back(out_data);
      if (frame_done) fd_cnt++;
      if (force_left > 0 && rdreq) stall_rd++;
      if (rdreq) begin
         check("rdreq_while_empty", 32'(rdq_empty), 0);
         pops++;
         if (q.size() > 0) begin
            pend      = q.pop_front();
            have_pend = 1;
         end
      end
      if (busy) begin
         busy_cyc++;
         seen_busy = 1;
      end else if (seen_busy) idle_cyc++;
      prev_v = out_valid;
      prev_r = out_ready;
      prev_c = clear;
      prev_d = out_data;
   endtask

   task automatic start();
      got.delete();
      exp_b.delete();
      pops = 0; fd_cnt = 0; busy_cyc = 0; idle_cyc = 0; seen_busy = 0;
   endtask

   task automatic load(input logic [8*P-1:0] pl);
      for (int i = 0; i < P; i++) q.push_back(pl[8*(P-1-i) +: 8]);
   endtask

   // Expected frame: sync, seq, payload, then (seq + sum(payload)) mod 256.
   task automatic add_frame(input logic [8*P-1:0] pl);
      int sum;
      sum = int'(mseq);
      exp_b.push_back(8'hAA);
      exp_b.push_back(8'h55);
      exp_b.push_back(mseq);
      for (int i = 0; i < P; i++) begin
         exp_b.push_back(pl[8*(P-1-i) +: 8]);
         sum += int'(pl[8*(P-1-i) +: 8]);
      end
      if (CK == 1) exp_b.push_back(8'(sum % 256));
      mseq = 8'((int'(mseq) + 1) % 256);
   endtask

   task automatic run_until(input string tag, input int n, input int bound);
      int k;
      k = 0;
      while (!(fd_cnt >= n && !busy) && k < bound) begin
         cyc();
         k++;
      end
      check({tag, "_timeout"}, 32'(k < bound), 1);
   endtask

   task automatic cmp_stream(input string tag);
      check({tag, "_len"}, 32'(got.size()), 32'(exp_b.size()));
      for (int i = 0; i < got.size() && i < exp_b.size(); i++)
         check({tag, "_byte"}, 32'(got[i]), 32'(exp_b[i]));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r, r2;
      int k;
      bit forced;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_rdreq", 32'(rdreq), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_frames_sent", 32'(frames_sent), 0);
      check("rst_out_data", 32'(out_data), 0);

      // single frame, known payload
      start();
      load(32'h01020304);
      add_frame(32'h01020304);
      en = 1'b1;
      run_until("single", 1, 200);
      cmp_stream("single");
      check("single_done", 32'(fd_cnt), 1);
      check("single_frames_sent", 32'(frames_sent), 1);
      check("single_pops", 32'(pops), P);
      check("single_cycles", 32'(busy_cyc), CYC);
      check("single_idle", 32'(idle_cyc), 1);

      // threshold: three bytes never start, the fourth does next cycle
      start();
      r = $urandom;
      q.push_back(r[31:24]); q.push_back(r[23:16]); q.push_back(r[15:8]);
      repeat (4) cyc();
      check("thr_busy_low", 32'(busy), 0);
      check("thr_valid_low", 32'(out_valid), 0);
      q.push_back(r[7:0]);
      add_frame(r);
      cyc();
      check("thr_idle_edge", 32'(busy), 0);
      cyc();
      check("thr_sync0_valid", 32'(out_valid), 1);
      check("thr_sync0_data", 32'(out_data), 32'hAA);
      run_until("thr", 1, 200);
      cmp_stream("thr");
      check("thr_frames_sent", 32'(frames_sent), 2);

      // backpressure, with en dropped mid-frame
      start();
      ready_mode = 1;
      r = $urandom;
      load(r);
      add_frame(r);
      k = 0;
      while (!busy && k < 10) begin cyc(); k++; end
      check("bp_start", 32'(busy), 1);
      en = 1'b0;
      run_until("bp_en", 1, 400);
      en = 1'b1;
      cmp_stream("bp_en");
      check("bp_en_pops", 32'(pops), P);
      start();
      for (int f = 0; f < 3; f++) begin
         r = $urandom;
         load(r);
         add_frame(r);
      end
      run_until("bp3", 3, 1000);
      cmp_stream("bp3");
      check("bp3_done", 32'(fd_cnt), 3);
      check("bp3_frames_sent", 32'(frames_sent), 6);
      ready_mode = 0;

      // queue emptied externally while waiting for payload
      start();
      r = $urandom;
      load(r);
      add_frame(r);
      forced = 0;
      k = 0;
      while (!(fd_cnt >= 1 && !busy) && k < 200) begin
         cyc();
         k++;
         if (!forced && got.size() == 3) begin
            force_left = 6;
            forced = 1;
         end
      end
      check("empty_timeout", 32'(k < 200), 1);
      check("empty_no_rdreq", 32'(stall_rd), 0);
      cmp_stream("empty");
      check("empty_pops", 32'(pops), P);
      check("empty_cycles", 32'(busy_cyc), CYC + 5);
      check("empty_frames_sent", 32'(frames_sent), 7);

      // clear in idle, then 257 back-to-back frames through the seq wrap
      clear_req = 1;
      cyc();
      cyc();
      check("clr_frames_sent", 32'(frames_sent), 0);
      mseq = 8'h00;
      start();
      for (int f = 0; f < 257; f++) begin
         r = (f == 255) ? 32'h01000000 : $urandom;
         load(r);
         add_frame(r);
      end
      run_until("wrap", 257, 257 * (CYC + 1) + 50);
      cmp_stream("wrap");
      check("wrap_frames_sent", 32'(frames_sent), 257);
      check("wrap_done", 32'(fd_cnt), 257);
      check("wrap_pops", 32'(pops), 257 * P);
      check("wrap_busy_cycles", 32'(busy_cyc), 257 * CYC);
      check("wrap_idle_cycles", 32'(idle_cyc), 257);
      check("wrap_seq_ff", 32'(got[255*FL+2]), 32'hFF);
      check("wrap_f256_last", 32'(got[256*FL-1]), 32'h00);
      check("wrap_seq_00", 32'(got[256*FL+2]), 32'h00);

      // abort with clear while byte 2 is offered
      start();
      r = $urandom;
      load(r);
      k = 0;
      while (got.size() < 4 && k < 50) begin cyc(); k++; end
      check("abort_reach_b1", 32'(got.size()), 4);
      ready_mode = 2;
      k = 0;
      do begin cyc(); k++; end while (!out_valid && k < 10);
      check("abort_b2_valid", 32'(out_valid), 1);
      ready_mode = 0;
      clear_req = 1;
      cyc();
      check("abort_no_done", 32'(frame_done), 0);
      cyc();
      check("abort_valid_low", 32'(out_valid), 0);
      check("abort_busy_low", 32'(busy), 0);
      check("abort_frames_sent", 32'(frames_sent), 0);
      mseq = 8'h00;
      start();
      r2 = $urandom;
      load(r2);
      add_frame({r[15:0], r2[31:16]});
      run_until("post_abort", 1, 200);
      cmp_stream("post_abort");
      check("post_abort_frames_sent", 32'(frames_sent), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
